icap_writer: RTL and testbench



---
 rtl/icap_defs.sv | 27 ++
 rtl/icap_word_skid.sv | 38 +++
 rtl/icap_writer.sv | 169 ++++++++++++++++
 tb/tb_icap_writer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icap_defs.sv
// Shared definitions for the ICAP writer: FSM encoding, sync/DESYNC words
// and the in-place byte bit-reversal that maps file order to SelectMAP order.
package icap_defs;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } icap_state_t;

   localparam logic [15:0] SYNC_HI_WORD    = 16'hAA99;
   localparam logic [15:0] SYNC_LO_WORD    = 16'h5566;
   localparam logic [15:0] DESYNC_CMD_WORD = 16'h30A1;
   localparam logic [15:0] DESYNC_ARG_WORD = 16'h000D;

   function automatic logic [15:0] byte_reverse(input logic [15:0] word);
      logic [15:0] result;
      result = '0;
      for (int i = 0; i < 8; i++) begin
         result[i]     = word[7 - i];
         result[8 + i] = word[15 - i];
      end
      return result;
   endfunction

endpackage

// File: rtl/icap_word_skid.sv
// One-entry skid buffer between the FIFO read port and the ICAP output register.
// A word passes straight through when the consumer is ready, otherwise it is parked.
module icap_word_skid (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] out_data,
   output logic        full
);

   logic        stored_q;
   logic [15:0] data_q;

   assign out_valid = stored_q | in_valid;
   assign out_data  = stored_q ? data_q : in_data;
   // Also full when the arriving word is about to be parked, so the producer
   // never has a second word in flight with nowhere to land.
   assign full      = stored_q | (in_valid & ~out_ready);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         stored_q <= 1'b0;
         data_q   <= '0;
      end else if (stored_q) begin
         if (out_ready) begin
            stored_q <= 1'b0;
         end
      end else if (in_valid && !out_ready) begin
         stored_q <= 1'b1;
         data_q   <= in_data;
      end
   end

endmodule

// File: rtl/icap_writer.sv
// ICAP feeder: pops bitstream words from the reconfiguration FIFO, writes them
// to the ICAP port under BUSY back-pressure and tracks sync, DESYNC and timeout.
module icap_writer
   import icap_defs::*;
#(
   parameter logic [7:0]  TIMEOUT = 8'd255,
   parameter logic [15:0] SYNC_HI = SYNC_HI_WORD,
   parameter logic [15:0] SYNC_LO = SYNC_LO_WORD
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [15:0] fifo_dout_i,
   input  logic        fifo_empty_i,
   output logic        fifo_rd_en_o,
   input  logic        icap_busy_i,
   output logic        icap_ce_n_o,
   output logic        icap_write_n_o,
   output logic [15:0] icap_i_o,
   output logic [15:0] word_count_o,
   output logic        synced_o,
   output logic        done_o,
   output logic        error_o
);

   icap_state_t state_q, state_d;

   logic        rd_en_q;
   logic        out_valid_q;
   logic [15:0] out_word_q;
   logic [15:0] last_word_q;
   logic [15:0] word_count_q;
   logic        synced_q;
   logic        done_q;
   logic        error_q;
   logic [7:0]  timer_q;

   logic        run;
   logic        accept;
   logic        out_ready;
   logic        load;
   logic        done_hit;
   logic        timeout_hit;
   logic        skid_in_valid;
   logic        skid_clear;
   logic        skid_valid;
   logic        skid_full;
   logic [15:0] skid_data;

   assign run           = (state_q == ST_RUN);
   assign accept        = run & out_valid_q & ~icap_busy_i;
   assign out_ready     = ~out_valid_q | accept;
   assign skid_in_valid = rd_en_q & run;
   assign skid_clear    = ~run;
   assign load          = run & skid_valid & out_ready;
   assign done_hit      = accept & synced_q & (out_word_q == DESYNC_ARG_WORD)
                          & (last_word_q == DESYNC_CMD_WORD);
   assign timeout_hit   = run & out_valid_q & icap_busy_i & (timer_q == TIMEOUT - 8'd1);

   icap_word_skid u_skid (
      .clk       (clk),
      .reset     (reset_i),
      .clear     (skid_clear),
      .in_valid  (skid_in_valid),
      .in_data   (fifo_dout_i),
      .out_ready (out_ready),
      .out_valid (skid_valid),
      .out_data  (skid_data),
      .full      (skid_full)
   );

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // RUN only returns to IDLE once nothing is in flight, so an abort still
   // delivers every word already taken out of the FIFO.
   always_comb begin
      state_d      = state_q;
      fifo_rd_en_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            fifo_rd_en_o = start_i & ~fifo_empty_i & ~skid_full & ~done_hit & ~timeout_hit;
            if (done_hit) begin
               state_d = ST_DONE;
            end else if (timeout_hit) begin
               state_d = ST_ERROR;
            end else if (!start_i && !out_valid_q && !skid_valid) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE, ST_ERROR: begin
            if (!start_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         rd_en_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         out_word_q   <= '0;
         last_word_q  <= '0;
         word_count_q <= '0;
         synced_q     <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         timer_q      <= '0;
      end else begin
         rd_en_q <= fifo_rd_en_o;
         if (!run) begin
            out_valid_q <= 1'b0;
         end else if (load) begin
            out_valid_q <= 1'b1;
            out_word_q  <= skid_data;
         end else if (accept) begin
            out_valid_q <= 1'b0;
         end
         if (state_q == ST_IDLE && start_i) begin
            last_word_q  <= '0;
            word_count_q <= '0;
            synced_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            timer_q      <= '0;
         end else if (run) begin
            if (accept) begin
               last_word_q <= out_word_q;
               timer_q     <= '0;
               if (word_count_q != 16'hFFFF) begin
                  word_count_q <= word_count_q + 16'd1;
               end
               if (out_word_q == SYNC_LO && last_word_q == SYNC_HI) begin
                  synced_q <= 1'b1;
               end
            end else if (out_valid_q && icap_busy_i) begin
               timer_q <= timer_q + 8'd1;
            end
            if (done_hit) begin
               done_q <= 1'b1;
            end
            if (timeout_hit) begin
               error_q <= 1'b1;
            end
         end
      end
   end

   assign icap_ce_n_o    = ~accept;
   assign icap_write_n_o = 1'b0;
   assign icap_i_o       = byte_reverse(out_word_q);
   assign word_count_o   = word_count_q;
   assign synced_o       = synced_q;
   assign done_o         = done_q;
   assign error_o        = error_q;

endmodule

// File: tb/tb_icap_writer.sv
// Directed self-checking bench for icap_writer with a behavioural FIFO read port.
module tb_icap_writer;

   logic        clk;
   logic        reset_i;
   logic        start_i;
   logic [15:0] fifo_dout_i;
   logic        fifo_empty_i;
   logic        fifo_rd_en_o;
   logic        icap_busy_i;
   logic        icap_ce_n_o;
   logic        icap_write_n_o;
   logic [15:0] icap_i_o;
   logic [15:0] word_count_o;
   logic        synced_o;
   logic        done_o;
   logic        error_o;

   int checks = 0;
   int failures = 0;

   logic [15:0] fifo_q[$];
   logic [15:0] written[$];
   int          pulses;
   int          cycle;
   int          first_pop;
   int          first_ce;
   int          last_ce_cycle;
   int          underflow;
   bit          record_en;
   logic        last_ce;
   logic [15:0] last_icap;
   logic [4:0]  synced_hist;
   logic [4:0]  done_hist;
   logic [15:0] count_hist[5];
   logic [15:0] exp_words[5];

   icap_writer dut (
      .clk            (clk),
      .reset_i        (reset_i),
      .start_i        (start_i),
      .fifo_dout_i    (fifo_dout_i),
      .fifo_empty_i   (fifo_empty_i),
      .fifo_rd_en_o   (fifo_rd_en_o),
      .icap_busy_i    (icap_busy_i),
      .icap_ce_n_o    (icap_ce_n_o),
      .icap_write_n_o (icap_write_n_o),
      .icap_i_o       (icap_i_o),
      .word_count_o   (word_count_o),
      .synced_o       (synced_o),
      .done_o         (done_o),
      .error_o        (error_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe at the falling edge, then serve the FIFO pop just after the rising edge.
   task automatic step_cycle();
      logic pop_now;
      @(negedge clk);
      last_ce   = icap_ce_n_o;
      last_icap = icap_i_o;
      pop_now   = fifo_rd_en_o;
      if (pop_now && first_pop < 0) first_pop = cycle;
      if (!icap_ce_n_o) begin
         if (first_ce < 0) first_ce = cycle;
         last_ce_cycle = cycle;
         if (pulses < 5) begin
            synced_hist[pulses] = synced_o;
            done_hist[pulses]   = done_o;
            count_hist[pulses]  = word_count_o;
         end
         if (record_en) written.push_back(icap_i_o);
         pulses++;
      end
      @(posedge clk);
      #1;
      if (pop_now) begin
         if (fifo_q.size() > 0) fifo_dout_i = fifo_q.pop_front();
         else underflow++;
      end
      fifo_empty_i = (fifo_q.size() == 0);
      cycle++;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) step_cycle();
   endtask

   task automatic push_word(input logic [15:0] w);
      fifo_q.push_back(w);
      fifo_empty_i = 1'b0;
   endtask

   task automatic new_test();
      written.delete();
      pulses        = 0;
      first_pop     = -1;
      first_ce      = -1;
      last_ce_cycle = -1;
      synced_hist   = '0;
      done_hist     = '0;
      record_en     = 1'b1;
   endtask

   task automatic check_written(input string tag, input int n);
      check_output({tag, "_nwords"}, written.size(), n);
      for (int i = 0; i < n && i < written.size(); i++) begin
         check_output($sformatf("%s_word%0d", tag, i), written[i], exp_words[i]);
      end
   endtask

   initial begin
      reset_i      = 1'b1;
      start_i      = 1'b0;
      fifo_dout_i  = '0;
      fifo_empty_i = 1'b1;
      icap_busy_i  = 1'b0;
      cycle        = 0;
      underflow    = 0;
      new_test();

      // Reset state
      run_cycles(2);
      check_output("rst_ce_n", icap_ce_n_o, 1);
      check_output("rst_write_n", icap_write_n_o, 0);
      check_output("rst_icap_i", icap_i_o, 16'h0000);
      check_output("rst_count", word_count_o, 0);
      check_output("rst_status", {synced_o, done_o, error_o, fifo_rd_en_o}, 4'b0000);
      reset_i = 1'b0;
      run_cycles(1);

      // Full sequence: padding, sync, DESYNC
      new_test();
      push_word(16'hFFFF); push_word(16'hAA99); push_word(16'h5566);
      push_word(16'h30A1); push_word(16'h000D);
      start_i = 1'b1;
      run_cycles(12);
      exp_words = '{16'hFFFF, 16'h5599, 16'hAA66, 16'h0C85, 16'h00B0};
      check_written("t1", 5);
      check_output("t1_latency", first_ce - first_pop, 2);
      check_output("t1_back_to_back", last_ce_cycle - first_ce, 4);
      check_output("t1_synced_hist", synced_hist, 5'b11000);
      check_output("t1_done_hist", done_hist, 5'b00000);
      check_output("t1_count_at_p3", count_hist[3], 16'd3);
      check_output("t1_status", {synced_o, done_o, error_o}, 3'b110);
      check_output("t1_count", word_count_o, 16'd5);
      check_output("t1_idle_ce", last_ce, 1);
      start_i = 1'b0;
      run_cycles(2);
      check_output("t1_done_held", done_o, 1);

      // BUSY for three cycles with a word pending
      new_test();
      push_word(16'h1234); push_word(16'h5678); push_word(16'h9ABC); push_word(16'hDEF0);
      start_i = 1'b1;
      run_cycles(3);
      icap_busy_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step_cycle();
         check_output($sformatf("t2_busy_ce%0d", i), last_ce, 1);
         check_output($sformatf("t2_busy_data%0d", i), last_icap, 16'h482C);
      end
      icap_busy_i = 1'b0;
      run_cycles(12);
      exp_words = '{16'h482C, 16'h6A1E, 16'h593D, 16'h7B0F, 16'h0000};
      check_written("t2", 4);
      check_output("t2_count", word_count_o, 16'd4);
      check_output("t2_status", {synced_o, done_o, error_o}, 3'b000);
      start_i = 1'b0;
      run_cycles(3);

      // BUSY timeout
      new_test();
      push_word(16'h1111); push_word(16'h2222); push_word(16'h3333);
      start_i = 1'b1;
      run_cycles(3);
      icap_busy_i = 1'b1;
      run_cycles(254);
      check_output("t3_no_error_254", error_o, 0);
      run_cycles(1);
      check_output("t3_error_255", error_o, 1);
      run_cycles(5);
      icap_busy_i = 1'b0;
      run_cycles(4);
      check_output("t3_fifo_left", fifo_q.size(), 1);
      check_output("t3_no_writes", pulses, 0);
      start_i = 1'b0;
      run_cycles(2);
      check_output("t3_error_held", error_o, 1);
      fifo_q.delete();
      fifo_empty_i = 1'b1;

      // Abort after two words popped
      new_test();
      push_word(16'h0101); push_word(16'h0202); push_word(16'h0303);
      push_word(16'h0404); push_word(16'h0505); push_word(16'h0606);
      start_i = 1'b1;
      run_cycles(3);
      start_i = 1'b0;
      run_cycles(6);
      exp_words = '{16'h8080, 16'h4040, 16'h0000, 16'h0000, 16'h0000};
      check_written("t4", 2);
      check_output("t4_fifo_left", fifo_q.size(), 4);
      check_output("t4_count", word_count_o, 16'd2);
      check_output("t4_status", {synced_o, done_o, error_o}, 3'b000);
      check_output("t4_no_pop", fifo_rd_en_o, 0);
      fifo_q.delete();
      fifo_empty_i = 1'b1;

      // DESYNC before sync, FIFO running dry, then a real sync and DESYNC
      new_test();
      push_word(16'h30A1); push_word(16'h000D);
      start_i = 1'b1;
      run_cycles(8);
      exp_words = '{16'h0C85, 16'h00B0, 16'h0000, 16'h0000, 16'h0000};
      check_written("t5", 2);
      check_output("t5_no_done_unsynced", done_o, 0);
      check_output("t5_count", word_count_o, 16'd2);
      run_cycles(20);
      check_output("t5_empty_wait", {done_o, error_o}, 2'b00);
      push_word(16'hAA99); push_word(16'h5566);
      run_cycles(8);
      check_output("t5_synced", {synced_o, done_o}, 2'b10);
      push_word(16'h30A1); push_word(16'h000D);
      run_cycles(8);
      check_output("t5_done", done_o, 1);
      check_output("t5_count_final", word_count_o, 16'd6);
      start_i = 1'b0;
      run_cycles(2);

      // Word count saturation
      new_test();
      record_en = 1'b0;
      for (int i = 0; i < 65540; i++) fifo_q.push_back(16'h0F0F);
      fifo_empty_i = 1'b0;
      start_i = 1'b1;
      run_cycles(65550);
      check_output("t6_pulses", pulses, 65540);
      check_output("t6_saturated", word_count_o, 16'hFFFF);
      check_output("t6_no_error", error_o, 0);

      // Reset in the middle of a transfer
      for (int i = 0; i < 5; i++) push_word(16'h0F0F);
      run_cycles(3);
      reset_i = 1'b1;
      run_cycles(1);
      check_output("t7_count", word_count_o, 16'd0);
      check_output("t7_ce_n", icap_ce_n_o, 1);
      check_output("t7_icap_i", icap_i_o, 16'h0000);
      check_output("t7_status", {synced_o, done_o, error_o, fifo_rd_en_o}, 4'b0000);
      reset_i = 1'b0;
      start_i = 1'b0;
      run_cycles(2);

      check_output("fifo_underflow", underflow, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
